// File: rtl/grid_rr_arbiter.sv
// grid_rr_arbiter: round-robin arbiter that shares one downstream resource
// among a ROWS x COLS array of requesters (flattened row-major). The owner
// keeps the grant while it requests, for at most MAX_HOLD cycles, and every
// ownership change goes through a single-cycle turnaround (COOL) state.
module grid_rr_arbiter #(
  parameter int ROWS     = 3,
  parameter int COLS     = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [ROWS*COLS-1:0]                     req,
  output logic [ROWS*COLS-1:0]                     gnt,
  output logic                                     gnt_valid,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] gnt_row,
  output logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0] gnt_col,
  output logic                                     preempt
);

  localparam int N  = ROWS * COLS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    COOL = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [IW-1:0]   ptr, ptr_n;
  logic [IW-1:0]   owner, owner_n;
  logic [HW-1:0]   hold_cnt, hold_n;
  logic [N-1:0]    gnt_n;
  logic            valid_n;
  logic [RW-1:0]   row_n;
  logic [CW-1:0]   col_n;
  logic            preempt_n;
  logic            found;
  logic [IW-1:0]   win;
  int              cand;

  // State and output registers; reset clears everything, including the rotation pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_row   <= '0;
      gnt_col   <= '0;
      preempt   <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      owner     <= owner_n;
      hold_cnt  <= hold_n;
      gnt       <= gnt_n;
      gnt_valid <= valid_n;
      gnt_row   <= row_n;
      gnt_col   <= col_n;
      preempt   <= preempt_n;
    end
  end

  // Circular priority scan starting at ptr, then the next-state/output decision.
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    owner_n   = owner;
    hold_n    = hold_cnt;
    gnt_n     = gnt;
    valid_n   = gnt_valid;
    row_n     = gnt_row;
    col_n     = gnt_col;
    preempt_n = 1'b0;
    found     = 1'b0;
    win       = '0;
    cand      = 0;

    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = IW'(cand);
      end
    end

    case (state)
      IDLE, COOL: begin
        if (found) begin
          gnt_n      = '0;
          gnt_n[win] = 1'b1;
          valid_n    = 1'b1;
          row_n      = RW'(int'(win) / COLS);
          col_n      = CW'(int'(win) % COLS);
          owner_n    = win;
          hold_n     = '0;
          state_n    = BUSY;
        end else begin
          state_n = IDLE;
        end
      end
      BUSY: begin
        if (!req[owner] ||
            (MAX_HOLD != 0 && int'(hold_cnt) == MAX_HOLD - 1)) begin
          gnt_n     = '0;
          valid_n   = 1'b0;
          row_n     = '0;
          col_n     = '0;
          ptr_n     = IW'((int'(owner) + 1) % N);
          preempt_n = req[owner];
          state_n   = COOL;
        end else if (hold_cnt != '1) begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_grid_rr_arbiter.sv
// tb_grid_rr_arbiter: drives two arbiters (default timeout and timeout
// disabled) with directed and random request patterns and compares every
// output each cycle against a behavioural round-robin model.
module tb_grid_rr_arbiter;

  localparam int ROWS = 3;
  localparam int COLS = 2;
  localparam int N    = ROWS * COLS;

  logic         clk;
  logic         reset;
  logic [N-1:0] req;

  logic [N-1:0] gnt_a, gnt_b;
  logic         valid_a, valid_b;
  logic [1:0]   row_a, row_b;
  logic [0:0]   col_a, col_b;
  logic         pre_a, pre_b;

  int checks;
  int passes;

  // Behavioural model state, one slot per DUT: owner index (-1 = nobody),
  // cycles the owner has held the grant, next scan start, preempt pulse.
  int mOwner[2];
  int mHeld[2];
  int mPtr[2];
  int mPre[2];
  int mMax[2];

  grid_rr_arbiter #(.ROWS(ROWS), .COLS(COLS), .MAX_HOLD(8)) dutA (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt_a), .gnt_valid(valid_a),
    .gnt_row(row_a), .gnt_col(col_a), .preempt(pre_a)
  );

  grid_rr_arbiter #(.ROWS(ROWS), .COLS(COLS), .MAX_HOLD(0)) dutB (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt_b), .gnt_valid(valid_b),
    .gnt_row(row_b), .gnt_col(col_b), .preempt(pre_b)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed == expected) passes++;
    else $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, observed, expected);
  endtask

  // One clock edge of the model: reset, else hold/release, else arbitrate.
  task automatic modelStep(input int m, input logic [N-1:0] r, input logic rst);
    if (rst) begin
      mOwner[m] = -1; mHeld[m] = 0; mPtr[m] = 0; mPre[m] = 0;
    end else begin
      mPre[m] = 0;
      if (mOwner[m] >= 0) begin
        if (!r[mOwner[m]]) begin
          mPtr[m] = (mOwner[m] + 1) % N;
          mOwner[m] = -1;
        end else if (mMax[m] != 0 && mHeld[m] + 1 == mMax[m]) begin
          mPtr[m] = (mOwner[m] + 1) % N;
          mOwner[m] = -1;
          mPre[m] = 1;
        end else begin
          mHeld[m] = mHeld[m] + 1;
        end
      end else begin
        for (int k = 0; k < N; k++) begin
          if (mOwner[m] < 0 && r[(mPtr[m] + k) % N]) begin
            mOwner[m] = (mPtr[m] + k) % N;
            mHeld[m] = 0;
          end
        end
      end
    end
  endtask

  task automatic compareAll();
    int o;
    o = mOwner[0];
    checkOutput("A.gnt",     int'(gnt_a),   (o >= 0) ? (1 << o) : 0);
    checkOutput("A.valid",   int'(valid_a), (o >= 0) ? 1 : 0);
    checkOutput("A.row",     int'(row_a),   (o >= 0) ? o / COLS : 0);
    checkOutput("A.col",     int'(col_a),   (o >= 0) ? o % COLS : 0);
    checkOutput("A.preempt", int'(pre_a),   mPre[0]);
    o = mOwner[1];
    checkOutput("B.gnt",     int'(gnt_b),   (o >= 0) ? (1 << o) : 0);
    checkOutput("B.valid",   int'(valid_b), (o >= 0) ? 1 : 0);
    checkOutput("B.row",     int'(row_b),   (o >= 0) ? o / COLS : 0);
    checkOutput("B.col",     int'(col_b),   (o >= 0) ? o % COLS : 0);
    checkOutput("B.preempt", int'(pre_b),   mPre[1]);
  endtask

  // Check outputs mid-cycle, then drive the inputs for the next edge and advance the model.
  task automatic applyStimulus(input logic [N-1:0] r, input logic rst);
    @(negedge clk);
    compareAll();
    req   = r;
    reset = rst;
    modelStep(0, r, rst);
    modelStep(1, r, rst);
  endtask

  initial begin
    logic [N-1:0] r;
    checks = 0;
    passes = 0;
    mMax[0] = 8;
    mMax[1] = 0;
    modelStep(0, '0, 1'b1);
    modelStep(1, '0, 1'b1);
    reset = 1'b1;
    req   = '0;

    applyStimulus('0, 1'b1);
    applyStimulus('0, 1'b0);

    // Single requester 0 holding for a few cycles then dropping.
    for (int i = 0; i < 4; i++) applyStimulus(6'b000001, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(6'b000000, 1'b0);

    // Everyone requests; the current owner drops after two granted cycles.
    for (int i = 0; i < 30; i++) begin
      r = 6'b111111;
      if (mOwner[0] >= 0 && mHeld[0] >= 1) r[mOwner[0]] = 1'b0;
      applyStimulus(r, 1'b0);
    end
    for (int i = 0; i < 3; i++) applyStimulus(6'b000000, 1'b0);

    // Lone requester 3 held continuously: timeout, preempt, re-grant.
    for (int i = 0; i < 30; i++) applyStimulus(6'b001000, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(6'b000000, 1'b0);

    // Requesters 1 and 4 always high: alternation under timeout.
    for (int i = 0; i < 45; i++) applyStimulus(6'b010010, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(6'b000000, 1'b0);

    // Reset during a grant to 5, then 0 and 5 compete with ptr back at 0.
    applyStimulus(6'b000000, 1'b1);
    applyStimulus(6'b100000, 1'b0);
    applyStimulus(6'b100000, 1'b0);
    applyStimulus(6'b100000, 1'b0);
    applyStimulus(6'b100001, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(6'b100001, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(6'b000000, 1'b0);

    // Requester 2 for 20 cycles: timeout-free instance never lets go.
    for (int i = 0; i < 20; i++) applyStimulus(6'b000100, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(6'b000000, 1'b0);

    // Random traffic with sticky requests and occasional reset.
    r = '0;
    for (int i = 0; i < 800; i++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      end
      applyStimulus(r, ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
    end
    applyStimulus('0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
